// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants and types for the data RAM arbiter: bus constants, FSM
// state encodings and requester port ids.
package data_ram_arbiter_pkg;

  localparam int DataBusW     = 32;
  localparam int DataAddrBusW = 32;

  localparam logic ChipEna  = 1'b1;
  localparam logic ChipDisa = 1'b0;
  localparam logic IsWrite  = 1'b1;
  localparam logic IsRead   = 1'b0;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_P0 = 1'b0,
    ARB_P1 = 1'b1
  } arb_port_e;

  function automatic arb_port_e other_port(input arb_port_e p);
    return (p == ARB_P0) ? ARB_P1 : ARB_P0;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, on conflict the port that
// was not served last wins.
module rr_arb2
  import data_ram_arbiter_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  arb_port_e last,
  output arb_port_e gnt,
  output logic      valid
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt   = ARB_P0;
    valid = req0 | req1;
    if (req0 && req1) gnt = other_port(last);
    else if (req1)    gnt = ARB_P1;
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the MEM stage (port 0) and the
// DMA/debug loader (port 1). Optional atomic lock on port 0: DATA_ARB_LOCK_EN.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DataAddrBusW,
  parameter int DATA_W = DataBusW,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [SEL_W-1:0]  sel0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [SEL_W-1:0]  sel1_i,
  input  logic [DATA_W-1:0] wdata1_i,
`ifdef DATA_ARB_LOCK_EN
  input  logic              lock0_i,
`endif
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              stall_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  arb_state_e state_q, state_d;
  arb_port_e  gnt_q, gnt_d;
  arb_port_e  last_q, last_d;
  arb_port_e  pick_gnt;
  logic       pick_valid;
  logic       serve;
  logic       hold;
  logic       other_req;

  rr_arb2 u_rr_arb2 (
    .req0  (req0_i),
    .req1  (req1_i),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

`ifdef DATA_ARB_LOCK_EN
  logic lock_q;

  // A lock seen in a port-0 ACCESS cycle pins the grant for the next cycle.
  assign hold  = (state_q == ARB_ACCESS) && (gnt_q == ARB_P0) && lock0_i;
  assign serve = (state_q == ARB_ACCESS) && (!lock_q || req0_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= hold;
  end
`else
  assign hold  = 1'b0;
  assign serve = (state_q == ARB_ACCESS);
`endif

  assign other_req = (gnt_q == ARB_P0) ? req1_i : req0_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= ARB_P0;
      last_q  <= ARB_P1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_ACCESS;
          gnt_d   = pick_gnt;
        end
      end
      ARB_ACCESS: begin
        if (serve) last_d = gnt_q;
        // Hand over straight to a waiting port so neither side is served twice in a row.
        if (!hold) begin
          if (other_req) gnt_d = other_port(gnt_q);
          else           state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    ram_ce_o   = ChipDisa;
    ram_we_o   = IsRead;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    ack0_o     = 1'b0;
    ack1_o     = 1'b0;
    rdata0_o   = '0;
    rdata1_o   = '0;
    if (serve) begin
      ram_ce_o = ChipEna;
      if (gnt_q == ARB_P0) begin
        ram_we_o   = we0_i;
        ram_addr_o = addr0_i;
        ram_sel_o  = sel0_i;
        ram_data_o = wdata0_i;
        ack0_o     = 1'b1;
        if (we0_i != IsWrite) rdata0_o = ram_data_i;
      end else begin
        ram_we_o   = we1_i;
        ram_addr_o = addr1_i;
        ram_sel_o  = sel1_i;
        ram_data_o = wdata1_i;
        ack1_o     = 1'b1;
        if (we1_i != IsWrite) rdata1_o = ram_data_i;
      end
    end
  end

  assign stall_o = req0_i & ~ack0_o;

`ifndef SYNTHESIS
  // Requesters must hold their fields until acked (or withdraw the request).
  a_hold0: assert property (@(posedge clk) disable iff (!rst_n)
    (req0_i && !ack0_o) |=> (!req0_i || $stable({we0_i, addr0_i, sel0_i, wdata0_i})));
  a_hold1: assert property (@(posedge clk) disable iff (!rst_n)
    (req1_i && !ack1_o) |=> (!req1_i || $stable({we1_i, addr1_i, sel1_i, wdata1_i})));
  a_one_ack: assert property (@(posedge clk) disable iff (!rst_n) !(ack0_o && ack1_o));
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural data RAM and a
// scoreboard of expected acks/read data (lock case built with DATA_ARB_LOCK_EN).
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [3:0]  sel0, sel1;
  logic        ack0_o, ack1_o, stall_o;
  logic [31:0] rdata0_o, rdata1_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;
`ifdef DATA_ARB_LOCK_EN
  logic        lock0;
`endif

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  data_ram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_i     (req0),
    .we0_i      (we0),
    .addr0_i    (addr0),
    .sel0_i     (sel0),
    .wdata0_i   (wdata0),
    .req1_i     (req1),
    .we1_i      (we1),
    .addr1_i    (addr1),
    .sel1_i     (sel1),
    .wdata1_i   (wdata1),
`ifdef DATA_ARB_LOCK_EN
    .lock0_i    (lock0),
`endif
    .ack0_o     (ack0_o),
    .ack1_o     (ack1_o),
    .rdata0_o   (rdata0_o),
    .rdata1_o   (rdata1_o),
    .stall_o    (stall_o),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i)
  );

  // Behavioural single-port RAM: combinational read, byte-lane write on the edge.
  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  assign ram_data_i = mem[ram_addr_o[7:2]];
  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o)
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: every ack pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (ack0_o || ack1_o)) begin
      check("one_ack", 32'(ack0_o & ack1_o), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({ack1_o, ack0_o}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", 32'(ack1_o), 32'(e.port));
        check("rdata", ack1_o ? rdata1_o : rdata0_o, e.rdata);
      end
    end
  end

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
    if (!port) begin
      req0 = req; we0 = we; addr0 = addr; sel0 = sel; wdata0 = wdata;
    end else begin
      req1 = req; we1 = we; addr1 = addr; sel1 = sel; wdata1 = wdata;
    end
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  // Uncontended transfer: idle cycle N, ACCESS/ack at N+1, request dropped after ack.
  task automatic xfer(input logic port, input logic we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input string tag);
    sb.push_back('{port, exp_rd});
    drive(port, 1'b1, we, addr, sel, wdata);
    @(negedge clk);
    check({tag, "_n_acks"}, 32'({ack1_o, ack0_o}), 32'd0);
    check({tag, "_n_ce"}, 32'(ram_ce_o), 32'd0);
    check({tag, "_n_stall"}, 32'(stall_o), port ? 32'd0 : 32'd1);
    @(negedge clk);
    check({tag, "_n1_acks"}, 32'({ack1_o, ack0_o}), port ? 32'd2 : 32'd1);
    check({tag, "_n1_ce"}, 32'(ram_ce_o), 32'd1);
    check({tag, "_n1_we"}, 32'(ram_we_o), 32'(we));
    check({tag, "_n1_addr"}, ram_addr_o, addr);
    check({tag, "_n1_sel"}, 32'(ram_sel_o), 32'(sel));
    if (we) check({tag, "_n1_wdata"}, ram_data_o, wdata);
    check({tag, "_n1_stall"}, 32'(stall_o), 32'd0);
    cycle_start();
    drive(port, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
`ifdef DATA_ARB_LOCK_EN
    lock0 = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    check("rst_acks", 32'({ack1_o, ack0_o}), 32'd0);
    check("rst_ce", 32'(ram_ce_o), 32'd0);
    check("rst_stall_lo", 32'(stall_o), 32'd0);
    req0 = 1'b1;
    #1;
    check("rst_stall_hi", 32'(stall_o), 32'd1);
    check("rst_addr", ram_addr_o, 32'h0);
    req0 = 1'b0;
    cycle_start();
    rst_n = 1'b1;
    cycle_start();

    // MEM write then read back
    xfer(1'b0, 1'b1, 32'd4, 4'hF, 32'hDEADBEEF, 32'h0, "t2_wr");
    xfer(1'b0, 1'b0, 32'd4, 4'hF, 32'h0, 32'hDEADBEEF, "t2_rd");

    // Single byte-lane write merges into existing word
    xfer(1'b0, 1'b1, 32'd8, 4'hF, 32'h11223344, 32'h0, "t5_base");
    xfer(1'b0, 1'b1, 32'd8, 4'b0100, 32'h00AB0000, 32'h0, "t5_lane");
    xfer(1'b1, 1'b0, 32'd8, 4'hF, 32'h0, 32'h11AB3344, "t5_rd");

    // Conflict with last=1: port 0 at N+1, port 1 at N+2
    sb.push_back('{1'b0, 32'hDEADBEEF});
    sb.push_back('{1'b1, 32'h0});
    drive(1'b0, 1'b1, 1'b0, 32'd4, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'd12, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    check("t3_n_acks", 32'({ack1_o, ack0_o}), 32'd0);
    check("t3_n_stall", 32'(stall_o), 32'd1);
    @(negedge clk);
    check("t3_n1_acks", 32'({ack1_o, ack0_o}), 32'd1);
    check("t3_n1_stall", 32'(stall_o), 32'd0);
    check("t3_n1_addr", ram_addr_o, 32'd4);
    cycle_start();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("t3_n2_acks", 32'({ack1_o, ack0_o}), 32'd2);
    check("t3_n2_stall", 32'(stall_o), 32'd0);
    check("t3_n2_addr", ram_addr_o, 32'd12);
    check("t3_n2_we", 32'(ram_we_o), 32'd1);
    cycle_start();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("t3_n3_ce", 32'(ram_ce_o), 32'd0);

    // Both held: strict alternation with no idle cycle
    for (int i = 0; i < 8; i++)
      sb.push_back('{1'(i % 2), (i % 2 == 0) ? 32'hCAFEF00D : 32'h11AB3344});
    cycle_start();
    drive(1'b0, 1'b1, 1'b0, 32'd12, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd8, 4'hF, 32'h0);
    @(negedge clk);
    check("t4_n_acks", 32'({ack1_o, ack0_o}), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("t4_alt%0d", i), 32'({ack1_o, ack0_o}), (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("t4_ce%0d", i), 32'(ram_ce_o), 32'd1);
      cycle_start();
      if (i == 6) drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      if (i == 7) drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    @(negedge clk);
    check("t4_end_ce", 32'(ram_ce_o), 32'd0);
    check("t4_end_acks", 32'({ack1_o, ack0_o}), 32'd0);

    // Reset during a port-1 ACCESS: no ack, ce drops at once, IDLE afterwards
    cycle_start();
    drive(1'b1, 1'b1, 1'b0, 32'd4, 4'hF, 32'h0);
    @(negedge clk);
    check("t6_n_acks", 32'({ack1_o, ack0_o}), 32'd0);
    cycle_start();
    check("t6_access_ce", 32'(ram_ce_o), 32'd1);
    check("t6_access_addr", ram_addr_o, 32'd4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ce", 32'(ram_ce_o), 32'd0);
    check("t6_rst_ack1", 32'(ack1_o), 32'd0);
    @(negedge clk);
    check("t6_rst_ack1_neg", 32'(ack1_o), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle_start();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_ce", 32'(ram_ce_o), 32'd0);
    check("t6_post_acks", 32'({ack1_o, ack0_o}), 32'd0);

`ifdef DATA_ARB_LOCK_EN
    // Lock over two port-0 accesses (with an idle locked cycle); port 1 waits
    sb.push_back('{1'b0, 32'hDEADBEEF});
    sb.push_back('{1'b0, 32'h0});
    sb.push_back('{1'b1, 32'hCAFEF00D});
    cycle_start();
    drive(1'b0, 1'b1, 1'b0, 32'd4, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd12, 4'hF, 32'h0);
    lock0 = 1'b1;
    @(negedge clk);
    check("lk_n_acks", 32'({ack1_o, ack0_o}), 32'd0);
    @(negedge clk);
    check("lk_n1_acks", 32'({ack1_o, ack0_o}), 32'd1);
    cycle_start();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("lk_n2_acks", 32'({ack1_o, ack0_o}), 32'd0);
    check("lk_n2_ce", 32'(ram_ce_o), 32'd0);
    cycle_start();
    drive(1'b0, 1'b1, 1'b1, 32'd16, 4'hF, 32'h5A5A5A5A);
    lock0 = 1'b0;
    @(negedge clk);
    check("lk_n3_acks", 32'({ack1_o, ack0_o}), 32'd1);
    check("lk_n3_addr", ram_addr_o, 32'd16);
    cycle_start();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("lk_n4_acks", 32'({ack1_o, ack0_o}), 32'd2);
    cycle_start();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("lk_end_ce", 32'(ram_ce_o), 32'd0);
`endif

    cycle_start();
    cycle_start();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
